// File: rtl/alu_sequencer.sv
// Control-side sequencer for a 16-bit 74181-based ALU datapath: launches one operation,
// captures result/carry/zero, pulses done. Optional ALU_SEQ_SETTLE_EN adds settle cycles per pass.
module alu_sequencer #(
    parameter int   SETTLE_CYCLES = 2,
    parameter logic CARRY_RST     = 1'b0
) (
    input  logic        clock,
    input  logic        notReset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [15:0] opAHi,
    input  logic [15:0] opBHi,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [4:0]  aluF,
    output logic        aluCsel,
    output logic        aluUcin,
    output logic        aluFcin,
    output logic        notALUOE,
    output logic        notShiftOE,
    input  logic [15:0] aluY,
    input  logic        aluCout,
    input  logic        aluZout,
    output logic [15:0] result,
    output logic [15:0] resultHi,
    output logic        carryFlag,
    output logic        zeroFlag,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_EXEC_HI,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [4:0] f;
        logic       csel;
        logic       ucin;
        logic       nAluOe;
        logic       nShiftOe;
    } drive_t;

    localparam logic [3:0] OP_ADD32 = 4'hC;

    // Opcodes D..F decode to the all-released default so the bus is never driven for them.
    function automatic drive_t decodeOp(input logic [3:0] code);
        drive_t d;
        d          = '0;
        d.nAluOe   = 1'b1;
        d.nShiftOe = 1'b1;
        case (code)
            4'h0, 4'hC: begin d.f = 5'b10010; d.nAluOe = 1'b0; end
            4'h1:       begin d.f = 5'b10010; d.nAluOe = 1'b0; d.csel = 1'b1; end
            4'h2:       begin d.f = 5'b01100; d.nAluOe = 1'b0; d.ucin = 1'b1; end
            4'h3:       begin d.f = 5'b01100; d.nAluOe = 1'b0; d.csel = 1'b1; end
            4'h4:       begin d.f = 5'b00000; d.nAluOe = 1'b0; d.ucin = 1'b1; end
            4'h5:       begin d.f = 5'b11110; d.nAluOe = 1'b0; end
            4'h6:       begin d.f = 5'b10111; d.nAluOe = 1'b0; end
            4'h7:       begin d.f = 5'b11101; d.nAluOe = 1'b0; end
            4'h8:       begin d.f = 5'b01101; d.nAluOe = 1'b0; end
            4'h9:       begin d.f = 5'b00001; d.nAluOe = 1'b0; end
            4'hA:       begin d.f = 5'b00101; d.nShiftOe = 1'b0; end
            4'hB:       begin d.f = 5'b00010; d.nShiftOe = 1'b0; end
            default:    ;
        endcase
        return d;
    endfunction

    // Arithmetic and shift ops update C; logic ops and invalid codes leave it alone.
    function automatic logic writesCarry(input logic [3:0] code);
        return (code <= 4'h5) || (code == 4'hA) || (code == 4'hB) || (code == OP_ADD32);
    endfunction

    function automatic logic opValid(input logic [3:0] code);
        return code <= OP_ADD32;
    endfunction

    state_t      r_state;
    logic [3:0]  r_op;
    logic [15:0] r_opAHi;
    logic [15:0] r_opBHi;
    logic        r_zLo;
    logic [15:0] r_aluA;
    logic [15:0] r_aluB;
    logic [4:0]  r_aluF;
    logic        r_aluCsel;
    logic        r_aluUcin;
    logic        r_notALUOE;
    logic        r_notShiftOE;
    logic [15:0] r_result;
    logic [15:0] r_resultHi;
    logic        r_carryFlag;
    logic        r_zeroFlag;
    logic        r_busy;
    logic        r_done;

    drive_t      w_drv;
    logic        w_passEnd;

    assign w_drv = decodeOp(op);

    if (SETTLE_CYCLES < 0) begin : g_badSettle
        $error("SETTLE_CYCLES must be non-negative");
    end

`ifdef ALU_SEQ_SETTLE_EN
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] r_settleCnt;

    // Counts down inside a pass and reloads whenever a pass ends or the FSM is outside one.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_settleCnt <= CNT_LOAD;
        end else if ((r_state == S_EXEC || r_state == S_EXEC_HI) && (r_settleCnt != '0)) begin
            r_settleCnt <= r_settleCnt - 1'b1;
        end else begin
            r_settleCnt <= CNT_LOAD;
        end
    end

    assign w_passEnd = (r_settleCnt == '0);
`else
    assign w_passEnd = 1'b1;
`endif

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_state      <= S_IDLE;
            r_op         <= 4'h0;
            r_opAHi      <= 16'h0000;
            r_opBHi      <= 16'h0000;
            r_zLo        <= 1'b0;
            r_aluA       <= 16'h0000;
            r_aluB       <= 16'h0000;
            r_aluF       <= 5'b00000;
            r_aluCsel    <= 1'b0;
            r_aluUcin    <= 1'b0;
            r_notALUOE   <= 1'b1;
            r_notShiftOE <= 1'b1;
            r_result     <= 16'h0000;
            r_resultHi   <= 16'h0000;
            r_carryFlag  <= CARRY_RST;
            r_zeroFlag   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op         <= op;
                        r_opAHi      <= opAHi;
                        r_opBHi      <= opBHi;
                        r_aluA       <= opA;
                        r_aluB       <= opB;
                        r_aluF       <= w_drv.f;
                        r_aluCsel    <= w_drv.csel;
                        r_aluUcin    <= w_drv.ucin;
                        r_notALUOE   <= w_drv.nAluOe;
                        r_notShiftOE <= w_drv.nShiftOe;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_passEnd) begin
                        if (r_op == OP_ADD32) begin
                            // Low-word carry lands in C so aluFcin feeds it into the high pass.
                            r_result    <= aluY;
                            r_carryFlag <= aluCout;
                            r_zLo       <= aluZout;
                            r_aluA      <= r_opAHi;
                            r_aluB      <= r_opBHi;
                            r_aluCsel   <= 1'b1;
                            r_aluUcin   <= 1'b0;
                            r_state     <= S_EXEC_HI;
                        end else begin
                            if (opValid(r_op)) begin
                                r_result   <= aluY;
                                r_zeroFlag <= aluZout;
                                if (writesCarry(r_op)) begin
                                    r_carryFlag <= aluCout;
                                end
                            end
                            r_notALUOE   <= 1'b1;
                            r_notShiftOE <= 1'b1;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end

                S_EXEC_HI: begin
                    if (w_passEnd) begin
                        r_resultHi   <= aluY;
                        r_carryFlag  <= aluCout;
                        r_zeroFlag   <= r_zLo & aluZout;
                        r_notALUOE   <= 1'b1;
                        r_notShiftOE <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign aluA       = r_aluA;
    assign aluB       = r_aluB;
    assign aluF       = r_aluF;
    assign aluCsel    = r_aluCsel;
    assign aluUcin    = r_aluUcin;
    assign aluFcin    = r_carryFlag;
    assign notALUOE   = r_notALUOE;
    assign notShiftOE = r_notShiftOE;
    assign result     = r_result;
    assign resultHi   = r_resultHi;
    assign carryFlag  = r_carryFlag;
    assign zeroFlag   = r_zeroFlag;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural 74181/shifter model on the bus, vector table
// plus hand sequences for ignored start requests and reset during the ADD32 high pass.
module tb_alu_sequencer;

`ifdef ALU_SEQ_SETTLE_EN
    localparam int SET = 2;
`else
    localparam int SET = 0;
`endif
    localparam int PASS_LEN = 1 + SET;
    localparam int NVEC = 17;

    logic        clock;
    logic        notReset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] opA, opB, opAHi, opBHi;
    logic [15:0] aluA, aluB;
    logic [4:0]  aluF;
    logic        aluCsel, aluUcin, aluFcin, notALUOE, notShiftOE;
    logic [15:0] aluY;
    logic        aluCout, aluZout;
    logic [15:0] result, resultHi;
    logic        carryFlag, zeroFlag, busy, done;

    int nChecks;
    int nPass;

    alu_sequencer dut (
        .clock(clock), .notReset(notReset), .start(start), .op(op),
        .opA(opA), .opB(opB), .opAHi(opAHi), .opBHi(opBHi),
        .aluA(aluA), .aluB(aluB), .aluF(aluF), .aluCsel(aluCsel),
        .aluUcin(aluUcin), .aluFcin(aluFcin), .notALUOE(notALUOE),
        .notShiftOE(notShiftOE), .aluY(aluY), .aluCout(aluCout),
        .aluZout(aluZout), .result(result), .resultHi(resultHi),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU and shifter as seen on the shared result bus.
    logic [16:0] sum;
    logic        cin;
    always_comb begin
        sum     = 17'h0;
        aluY    = 16'h0000;
        aluCout = 1'b0;
        cin     = aluCsel ? aluFcin : aluUcin;
        if (!notShiftOE) begin
            case (aluF)
                5'b00101: begin aluY = {aluA[14:0], 1'b0}; aluCout = aluA[15]; end
                5'b00010: begin aluY = {1'b0, aluA[15:1]}; aluCout = aluA[0]; end
                default:  ;
            endcase
        end else if (!notALUOE) begin
            case (aluF)
                5'b10010: begin sum = {1'b0, aluA} + {1'b0, aluB} + {16'h0, cin};  aluY = sum[15:0]; aluCout = sum[16]; end
                5'b01100: begin sum = {1'b0, aluA} + {1'b0, ~aluB} + {16'h0, cin}; aluY = sum[15:0]; aluCout = sum[16]; end
                5'b00000: begin sum = {1'b0, aluA} + {16'h0, cin};                 aluY = sum[15:0]; aluCout = sum[16]; end
                5'b11110: begin sum = {1'b0, aluA} + 17'h0FFFF + {16'h0, cin};     aluY = sum[15:0]; aluCout = sum[16]; end
                5'b10111: aluY = aluA & aluB;
                5'b11101: aluY = aluA | aluB;
                5'b01101: aluY = aluA ^ aluB;
                5'b00001: aluY = ~aluA;
                default:  ;
            endcase
        end
        aluZout = (aluY == 16'h0000);
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, ahi, bhi;
        logic [15:0] expRes, expHi;
        logic        expC, expZ;
        int          passes;
        logic        chkDrv;
        logic [3:0]  expDrv;
        logic        chkHiFcin;
        logic        expHiFcin;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] ahi, input logic [15:0] bhi,
                                input logic [15:0] res, input logic [15:0] hi,
                                input logic c, input logic z, input int passes);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.ahi = ahi; v.bhi = bhi;
        v.expRes = res; v.expHi = hi; v.expC = c; v.expZ = z; v.passes = passes;
        v.chkDrv = 1'b0; v.expDrv = 4'h0; v.chkHiFcin = 1'b0; v.expHiFcin = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".result"},     32'(result),     32'h0);
        checkOutput({tag, ".resultHi"},   32'(resultHi),   32'h0);
        checkOutput({tag, ".carryFlag"},  32'(carryFlag),  32'h0);
        checkOutput({tag, ".zeroFlag"},   32'(zeroFlag),   32'h0);
        checkOutput({tag, ".busy"},       32'(busy),       32'h0);
        checkOutput({tag, ".done"},       32'(done),       32'h0);
        checkOutput({tag, ".notALUOE"},   32'(notALUOE),   32'h1);
        checkOutput({tag, ".notShiftOE"}, 32'(notShiftOE), 32'h1);
        checkOutput({tag, ".aluA"},       32'(aluA),       32'h0);
        checkOutput({tag, ".aluB"},       32'(aluB),       32'h0);
        checkOutput({tag, ".aluF"},       32'(aluF),       32'h0);
        checkOutput({tag, ".aluCsel"},    32'(aluCsel),    32'h0);
        checkOutput({tag, ".aluUcin"},    32'(aluUcin),    32'h0);
        checkOutput({tag, ".aluFcin"},    32'(aluFcin),    32'h0);
    endtask

    // Launches one request and follows it to done, recording drive lines along the way.
    task automatic applyStimulus(input vec_t v, output int lat, output logic [3:0] drv0,
                                 output logic hiFcin, output logic oeBoth);
        lat    = -1;
        drv0   = 4'h0;
        hiFcin = 1'b0;
        oeBoth = 1'b0;
        @(negedge clock);
        start = 1'b1; op = v.op; opA = v.a; opB = v.b; opAHi = v.ahi; opBHi = v.bhi;
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 1) drv0 = {aluCsel, aluFcin, notALUOE, notShiftOE};
            if (n == PASS_LEN + 1) hiFcin = aluFcin;
            if (!notALUOE && !notShiftOE) oeBoth = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clock);
        end
    endtask

    int         lat;
    logic [3:0] drv;
    logic       hiF;
    logic       oeBad;
    logic       doneSeen;
    int         cyc;

    initial begin
        nChecks = 0;
        nPass   = 0;

        vecs[0]  = mk(4'h0, 16'h0001, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);
        vecs[1]  = mk(4'h2, 16'h0005, 16'h0007, 16'h0, 16'h0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1);
        vecs[2]  = mk(4'h3, 16'h0009, 16'h0003, 16'h0, 16'h0, 16'h0005, 16'h0000, 1'b1, 1'b0, 1);
        vecs[3]  = mk(4'h1, 16'h1234, 16'h0001, 16'h0, 16'h0, 16'h1236, 16'h0000, 1'b0, 1'b0, 1);
        vecs[4]  = mk(4'h6, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1);
        vecs[5]  = mk(4'hA, 16'h8001, 16'h0000, 16'h0, 16'h0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1);
        vecs[6]  = mk(4'hB, 16'h8001, 16'h0000, 16'h0, 16'h0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1);
        vecs[7]  = mk(4'hC, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 2);
        vecs[8]  = mk(4'h4, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1);
        vecs[9]  = mk(4'h5, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        vecs[10] = mk(4'h7, 16'h1200, 16'h0034, 16'h0, 16'h0, 16'h1234, 16'h0001, 1'b0, 1'b0, 1);
        vecs[11] = mk(4'h8, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1);
        vecs[12] = mk(4'hE, 16'h5555, 16'hAAAA, 16'h0, 16'h0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1);
        vecs[13] = mk(4'h9, 16'h00FF, 16'h0000, 16'h0, 16'h0, 16'hFF00, 16'h0001, 1'b0, 1'b0, 1);
        vecs[14] = mk(4'hC, 16'h8000, 16'h8000, 16'h1234, 16'h0001, 16'h0000, 16'h1236, 1'b0, 1'b0, 2);
        vecs[15] = mk(4'hC, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 2);
        vecs[16] = mk(4'h2, 16'h0007, 16'h0007, 16'h0, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);

        // Drive snapshots are {aluCsel, aluFcin, notALUOE, notShiftOE} in the first EXEC cycle.
        vecs[2].chkDrv  = 1'b1; vecs[2].expDrv  = 4'b1001;
        vecs[5].chkDrv  = 1'b1; vecs[5].expDrv  = 4'b0010;
        vecs[7].chkDrv  = 1'b1; vecs[7].expDrv  = 4'b0101;
        vecs[7].chkHiFcin = 1'b1; vecs[7].expHiFcin = 1'b1;
        vecs[12].chkDrv = 1'b1; vecs[12].expDrv = 4'b0011;
        vecs[14].chkHiFcin = 1'b1; vecs[14].expHiFcin = 1'b1;

        notReset = 1'b0;
        start = 1'b0; op = 4'h0; opA = 16'h0; opB = 16'h0; opAHi = 16'h0; opBHi = 16'h0;
        repeat (2) @(negedge clock);
        checkReset("por");
        notReset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], lat, drv, hiF, oeBad);
            checkOutput($sformatf("v%0d.result", i),   32'(result),   32'(vecs[i].expRes));
            checkOutput($sformatf("v%0d.resultHi", i), 32'(resultHi), 32'(vecs[i].expHi));
            checkOutput($sformatf("v%0d.carry", i),    32'(carryFlag), 32'(vecs[i].expC));
            checkOutput($sformatf("v%0d.zero", i),     32'(zeroFlag),  32'(vecs[i].expZ));
            checkOutput($sformatf("v%0d.latency", i),  32'(lat), 32'(vecs[i].passes * PASS_LEN + 1));
            checkOutput($sformatf("v%0d.busyInDone", i), 32'(busy), 32'h1);
            checkOutput($sformatf("v%0d.oeExclusive", i), 32'(oeBad), 32'h0);
            if (vecs[i].chkDrv)
                checkOutput($sformatf("v%0d.drive", i), 32'(drv), 32'(vecs[i].expDrv));
            if (vecs[i].chkHiFcin)
                checkOutput($sformatf("v%0d.hiFcin", i), 32'(hiF), 32'(vecs[i].expHiFcin));
        end

        // start held high from EXEC through DONE with a different op must not launch anything.
        @(negedge clock);
        start = 1'b1; op = 4'hC; opA = 16'h0001; opB = 16'h0002; opAHi = 16'h0; opBHi = 16'h0;
        @(negedge clock);
        op = 4'h6; opA = 16'h0000; opB = 16'h0000;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        start = 1'b0;
        checkOutput("ign.latency",  32'(lat),      32'(2 * PASS_LEN + 1));
        checkOutput("ign.result",   32'(result),   32'h0003);
        checkOutput("ign.resultHi", 32'(resultHi), 32'h0000);
        checkOutput("ign.carry",    32'(carryFlag), 32'h0);
        checkOutput("ign.busyIdle", 32'(busy),     32'h0);
        doneSeen = done;
        repeat (4) begin
            @(negedge clock);
            doneSeen = doneSeen | done | busy;
        end
        checkOutput("ign.noSecondOp", 32'(doneSeen), 32'h0);

        // Reset asserted in the first EXEC_HI cycle of an ADD32.
        @(negedge clock);
        start = 1'b1; op = 4'hC; opA = 16'hFFFF; opB = 16'h0001; opAHi = 16'h0; opBHi = 16'h0;
        @(negedge clock);
        start = 1'b0;
        repeat (PASS_LEN) @(negedge clock);
        checkOutput("abort.hiPassFcin", 32'(aluFcin), 32'h1);
        notReset = 1'b0;
        #1;
        checkReset("abort");
        doneSeen = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(negedge clock);
            doneSeen = doneSeen | done;
        end
        notReset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            doneSeen = doneSeen | done | busy;
        end
        checkOutput("abort.noDone", 32'(doneSeen), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
